// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with runtime limit, load, wrap/saturate
// boundary handling and a registered terminal-count pulse.
module updown_counter_param #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO  = '0;

  logic [WIDTH-1:0] q_next;
  logic             tc_next;
  logic             below_lim;
  logic             at_lim;
  logic             above_lim;
  logic             is_zero;

  // Position of the current count relative to the live limit
  always_comb begin
    below_lim = (q < limit);
    at_lim    = (q == limit);
    above_lim = (q > limit);
    is_zero   = (q == ZERO);
  end

  // Next count and terminal-count event, priority rst > load > en
  always_comb begin
    q_next  = q;
    tc_next = 1'b0;
    if (rst) begin
      q_next = RST_Q;
    end else if (load) begin
      // Loads are clamped so the count never starts outside 0..limit
      q_next = (load_val > limit) ? limit : load_val;
    end else if (en) begin
      if (up_dn) begin
        if (below_lim) begin
          q_next = q + ONE;
        end else begin
          // At or above the limit: wrap to 0 or pin at limit; only an
          // exact hit of the limit counts as a terminal event
          q_next  = sat_mode ? limit : ZERO;
          tc_next = at_lim;
        end
      end else begin
        if (above_lim) begin
          // Limit was lowered under the count: pull back into range
          q_next = limit;
        end else if (is_zero) begin
          q_next  = sat_mode ? ZERO : limit;
          tc_next = 1'b1;
        end else begin
          q_next = q - ONE;
        end
      end
    end
  end

  // Count and terminal-count registers
  always_ff @(posedge clk) begin
    q  <= q_next;
    tc <= tc_next;
  end

  // Boundary flags decoded straight from the registered count
  always_comb begin
    at_max = (q >= limit);
    at_min = (q == ZERO);
  end

endmodule

// File: tb/tb_updown_counter_param.sv
// Scoreboard bench for updown_counter_param: legacy 3-bit down-counter
// equivalence plus directed and random checks on a 4-bit instance.
module tb_updown_counter_param;

  localparam int RST4 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Legacy-configured instance
  logic       l_rst, l_en, l_up_dn, l_load, l_sat_mode;
  logic [2:0] l_load_val, l_limit, l_q;
  logic       l_tc, l_at_max, l_at_min;

  // General 4-bit instance
  logic       rst, en, up_dn, load, sat_mode;
  logic [3:0] load_val, limit, q;
  logic       tc, at_max, at_min;

  updown_counter_param #(.WIDTH(3), .RESET_VAL(7)) u_legacy (
    .clk(clk), .rst(l_rst), .en(l_en), .up_dn(l_up_dn), .load(l_load),
    .load_val(l_load_val), .limit(l_limit), .sat_mode(l_sat_mode),
    .q(l_q), .tc(l_tc), .at_max(l_at_max), .at_min(l_at_min)
  );

  updown_counter_param #(.WIDTH(4), .RESET_VAL(RST4)) u_dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .limit(limit), .sat_mode(sat_mode),
    .q(q), .tc(tc), .at_max(at_max), .at_min(at_min)
  );

  typedef struct {
    int    q;
    int    tc;
    int    lim;
    string tag;
  } exp_t;

  exp_t sb[$];
  exp_t lsb[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   m_q      = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference behaviour of one clock edge
  function automatic void model(input int cur, input logic r, input logic ld,
                                input int lv, input logic e, input logic u,
                                input int lim, input logic s,
                                output int nq, output int ntc);
    nq  = cur;
    ntc = 0;
    if (r) nq = RST4;
    else if (ld) nq = (lv > lim) ? lim : lv;
    else if (e) begin
      if (u) begin
        if (cur < lim) nq = cur + 1;
        else begin
          nq  = s ? lim : 0;
          ntc = (cur == lim) ? 1 : 0;
        end
      end else begin
        if (cur > lim) nq = lim;
        else if (cur == 0) begin
          nq  = s ? 0 : lim;
          ntc = 1;
        end else nq = cur - 1;
      end
    end
  endfunction

  // Drive one cycle on the 4-bit instance, push the prediction, then
  // pop and compare once the edge has produced the new count
  task automatic drive(input logic r, input logic ld, input int lv,
                       input logic e, input logic u, input int lim,
                       input logic s, input string tag);
    exp_t x;
    int   nq, ntc;
    @(negedge clk);
    rst = r; load = ld; load_val = 4'(lv); en = e; up_dn = u;
    limit = 4'(lim); sat_mode = s;
    model(m_q, r, ld, lv, e, u, lim, s, nq, ntc);
    m_q = nq;
    sb.push_back('{q: nq, tc: ntc, lim: lim, tag: tag});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check({x.tag, "_q"}, int'(q), x.q);
    check({x.tag, "_tc"}, int'(tc), x.tc);
    check({x.tag, "_at_max"}, int'(at_max), (x.q >= x.lim) ? 1 : 0);
    check({x.tag, "_at_min"}, int'(at_min), (x.q == 0) ? 1 : 0);
  endtask

  task automatic ld(input int lv, input int lim, input string tag);
    drive(1'b0, 1'b1, lv, 1'b0, 1'b0, lim, 1'b0, tag);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t lx;
    int   lseq [10] = '{6, 5, 4, 3, 2, 1, 0, 7, 6, 5};

    rst = 1'b1; en = 1'b0; up_dn = 1'b0; load = 1'b0; load_val = '0;
    limit = 4'd9; sat_mode = 1'b0;
    l_rst = 1'b1; l_en = 1'b1; l_up_dn = 1'b0; l_load = 1'b0;
    l_load_val = '0; l_limit = 3'd7; l_sat_mode = 1'b0;

    // Legacy equivalence: reset to 7, then count down with wrap to 7
    @(negedge clk);
    lsb.push_back('{q: 7, tc: 0, lim: 7, tag: "legacy_rst"});
    @(posedge clk); #1;
    lx = lsb.pop_front();
    check({lx.tag, "_q"}, int'(l_q), lx.q);
    check({lx.tag, "_tc"}, int'(l_tc), lx.tc);
    @(negedge clk);
    l_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      lsb.push_back('{q: lseq[i], tc: (lseq[i] == 7) ? 1 : 0, lim: 7,
                      tag: $sformatf("legacy_%0d", i)});
      @(posedge clk); #1;
      lx = lsb.pop_front();
      check({lx.tag, "_q"}, int'(l_q), lx.q);
      check({lx.tag, "_tc"}, int'(l_tc), lx.tc);
    end

    // Reset state of the 4-bit instance
    drive(1'b1, 1'b0, 0, 1'b0, 1'b0, 9, 1'b0, "reset");
    check("reset_lit", int'(q), RST4);

    // Up count with wrap: 1..9 then 0 with tc
    ld(0, 9, "ld0");
    for (int i = 0; i < 10; i++)
      drive(1'b0, 1'b0, 0, 1'b1, 1'b1, 9, 1'b0, $sformatf("upwrap_%0d", i));
    check("upwrap_end_lit", int'(q), 0);

    // Up saturate: stuck at 9, tc every enabled cycle
    ld(9, 9, "ld9");
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b0, 0, 1'b1, 1'b1, 9, 1'b1, $sformatf("upsat_%0d", i));
    check("upsat_tc_lit", int'(tc), 1);
    check("upsat_atmax_lit", int'(at_max), 1);

    // Down at zero: wrap to limit, saturate holds 0
    ld(0, 9, "ld0b");
    drive(1'b0, 1'b0, 0, 1'b1, 1'b0, 9, 1'b0, "dnwrap");
    check("dnwrap_lit", int'(q), 9);
    ld(0, 9, "ld0c");
    drive(1'b0, 1'b0, 0, 1'b1, 1'b0, 9, 1'b1, "dnsat");

    // Load clamp and load ignoring en, then rst over load
    drive(1'b0, 1'b1, 12, 1'b1, 1'b1, 9, 1'b0, "clamp");
    check("clamp_lit", int'(q), 9);
    drive(1'b1, 1'b1, 5, 1'b1, 1'b1, 9, 1'b0, "rst_over_ld");
    check("rst_over_ld_lit", int'(q), RST4);

    // Limit lowered below the count
    ld(8, 9, "ld8a");
    drive(1'b0, 1'b0, 0, 1'b1, 1'b1, 5, 1'b0, "low_upwrap");
    check("low_upwrap_lit", int'(q), 0);
    ld(8, 9, "ld8b");
    drive(1'b0, 1'b0, 0, 1'b1, 1'b1, 5, 1'b1, "low_upsat");
    check("low_upsat_lit", int'(q), 5);
    ld(8, 9, "ld8c");
    drive(1'b0, 1'b0, 0, 1'b1, 1'b0, 5, 1'b0, "low_dn");
    check("low_dn_lit", int'(q), 5);

    // Enable gating while counting up from 3: 4,4,4,5
    ld(3, 9, "ld3");
    drive(1'b0, 1'b0, 0, 1'b1, 1'b1, 9, 1'b0, "gate_0");
    drive(1'b0, 1'b0, 0, 1'b0, 1'b1, 9, 1'b0, "gate_1");
    drive(1'b0, 1'b0, 0, 1'b0, 1'b1, 9, 1'b0, "gate_2");
    drive(1'b0, 1'b0, 0, 1'b1, 1'b1, 9, 1'b0, "gate_3");
    check("gate_lit", int'(q), 5);

    // Reset mid-count
    ld(6, 9, "ld6");
    drive(1'b1, 1'b0, 0, 1'b1, 1'b1, 9, 1'b0, "rst_mid");

    // Degenerate limit of zero, both directions and modes
    ld(0, 0, "ld_lim0");
    for (int i = 0; i < 4; i++)
      drive(1'b0, 1'b0, 0, 1'b1, i[0], 0, i[1], $sformatf("lim0_%0d", i));
    check("lim0_tc_lit", int'(tc), 1);

    // Full-range limit behaves as plain modulo-16
    ld(14, 15, "ld14");
    drive(1'b0, 1'b0, 0, 1'b1, 1'b1, 15, 1'b0, "full_0");
    drive(1'b0, 1'b0, 0, 1'b1, 1'b1, 15, 1'b0, "full_1");
    check("full_wrap_lit", int'(q), 0);

    // Random mix of all controls
    for (int i = 0; i < 300; i++)
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
            1'($urandom), int'($urandom_range(0, 15)), 1'($urandom),
            $sformatf("rnd_%0d", i));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
- Parametrised up/down counter; generalises the fixed 3-bit down counter.
- Adds:
  - configurable width and reset value;
  - runtime upper limit (modulus - 1);
  - direction control, count enable and synchronous parallel load;
  - wrap or saturate mode selected at runtime;
  - registered terminal-count pulse.
- Used as a timer/index generator in lab datapaths.
- With WIDTH=3, RESET_VAL=7, limit=7, up_dn=0, en=1 and sat_mode=0, it reproduces the legacy 3-bit down counter exactly.

Parameters:
- WIDTH, 8: counter width in bits; must be ≥ 1.
- RESET_VAL, 0: value of q after reset. Must be ≤ the limit used after reset; no clamping is applied at reset.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  count enable; one step per cycle while high.
- up_dn  input  1  direction: 1 = count up, 0 = count down.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value to load.
- limit  input  WIDTH  inclusive upper bound; legal range is 0..limit.
- sat_mode  input  1  boundary mode: 1 = saturate, 0 = wrap.
- q  output  WIDTH  registered count.
- tc  output  1  registered terminal-count pulse.
- at_max  output  1  combinational, equals (q >= limit).
- at_min  output  1  combinational, equals (q == 0).

Behaviour:
- Reset:
  - On a posedge with rst=1: q = RESET_VAL, tc = 0.
  - All other inputs are ignored that cycle.
  - Reset may arrive mid-count and takes effect on that edge.
- Priority per edge: rst > load > en. If none is active, q holds and tc = 0.
- Load (load=1):
  - q = min(load_val, limit); tc = 0.
  - en and up_dn are ignored that cycle.
- Enabled step (en=1, load=0), up_dn=1:
  - q < limit: q = q + 1, tc = 0.
  - q == limit: wrap gives q = 0; saturate holds q = limit; tc = 1 in both modes.
  - q > limit (limit lowered at runtime): wrap gives q = 0; saturate gives q = limit; tc = 0.
- Enabled step (en=1, load=0), up_dn=0:
  - 0 < q ≤ limit: q = q - 1, tc = 0.
  - q == 0: wrap gives q = limit; saturate holds q = 0; tc = 1 in both modes.
  - q > limit: q = limit in both modes; tc = 0.
- tc:
  - One-cycle pulse, registered and aligned with the new q value.
  - Continuous en at a boundary gives one pulse per wrap event.
  - In saturate mode with en held at the boundary, tc stays high every cycle (one event per step).
- Arithmetic:
  - Unsigned, WIDTH bits; no intermediate overflow.
  - limit = 2^WIDTH - 1 behaves as a natural modulo-2^WIDTH counter.
  - limit = 0: q stays 0; each enabled step asserts tc.
- Timing:
  - Latency is 1 cycle from the en/load sample edge to q update.
  - Changes to up_dn, limit and sat_mode take effect on the next edge.
- No X propagation: all next-state paths are fully specified.

Test Plan:
- Legacy equivalence: WIDTH=3, RESET_VAL=7, limit=7, en=1, up_dn=0, sat_mode=0; rst high 1 cycle then low.
  - Expect q sequence 7,6,5,4,3,2,1,0,7,6…
  - Expect tc=1 only in the cycle q returns to 7.
- Up wrap / saturate: WIDTH=4, limit=9, up_dn=1, from q=0.
  - Wrap: expect 0..9,0 with tc on the 9→0 transition.
  - Repeat with sat_mode=1: expect q stuck at 9, at_max=1, tc=1 each enabled cycle.
- Load clamp and priority: limit=9; load=1 with load_val=12, en=1.
  - Expect q=9, tc=0.
  - Then load=1 with load_val=5 and rst=1 simultaneously: expect q=RESET_VAL.
- Limit lowered: q=8; set limit=5; en=1.
  - up_dn=1, wrap: expect q→0, tc=0.
  - Saturate: expect q→5.
  - up_dn=0: expect q→5.
- Enable gating: en toggled 1,0,0,1 while counting up from 3.
  - Expect q = 4,4,4,5; tc=0 throughout.
- Reset mid-operation and degenerate limit:
  - rst asserted while q=6: expect q=RESET_VAL next edge.
  - limit=0, en=1: expect q=0 and tc=1 every cycle.
